// File: rtl/mc_datapath.sv
// mc_datapath: parametrised multicycle datapath driven by an external controller FSM.
// Holds PC, IR, the register file and the non-architectural registers A, B, ALUOut and Data.
// One shared instruction/data memory port; mem_ready=0 freezes every enabled write.
//
// Ports:
//   clk, reset         clock (posedge) and asynchronous active-low reset
//   mem_ready          memory access completes this cycle
//   pcen, irwrite      PC / IR write enables
//   iord               memory address select (0 = PC, 1 = ALUOut)
//   regdst, memtoreg   destination register and writeback data selects
//   regwrite           register file write enable
//   alusrca, alusrcb   ALU operand selects
//   alucontrol         ALU operation
//   pcsrc              next-PC select
//   readdata           memory read data
//   adr, writedata     memory address and write data
//   op, zero           opcode and ALU zero flag for the controller
module mc_datapath #(
    parameter int unsigned  N        = 16,
    parameter int unsigned  RA_W     = 3,
    parameter int unsigned  IMM_W    = 7,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_ready,
    input  logic         pcen,
    input  logic         iord,
    input  logic         irwrite,
    input  logic         regdst,
    input  logic         memtoreg,
    input  logic         regwrite,
    input  logic         alusrca,
    input  logic [1:0]   alusrcb,
    input  logic [2:0]   alucontrol,
    input  logic [1:0]   pcsrc,
    input  logic [N-1:0] readdata,
    output logic [N-1:0] adr,
    output logic [N-1:0] writedata,
    output logic [2:0]   op,
    output logic         zero
);

    localparam int unsigned SH   = (N == 32) ? 2 : 1;
    localparam int unsigned NREG = 2 ** RA_W;
    localparam logic [N-1:0] INSTR_BYTES = N'(N / 8);

    logic [N-1:0] pc_q, ir_q, a_q, b_q, aluout_q, data_q;
    logic [N-1:0] rf_q [NREG];

    logic [RA_W-1:0] rs, rt, rd, writereg;
    logic [N-1:0]    signimm, srca, srcb, alu_result, pcnext, wbdata;

    // Instruction fields
    assign op      = ir_q[N-1 -: 3];
    assign rs      = ir_q[N-4 -: RA_W];
    assign rt      = ir_q[N-4-RA_W -: RA_W];
    assign rd      = ir_q[N-4-2*RA_W -: RA_W];
    assign signimm = {{(N-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

    assign writereg  = regdst ? rd : rt;
    assign wbdata    = memtoreg ? data_q : aluout_q;
    assign adr       = iord ? aluout_q : pc_q;
    assign writedata = b_q;
    assign srca      = alusrca ? a_q : pc_q;

    always_comb begin
        srcb = b_q;
        unique case (alusrcb)
            2'b00: srcb = b_q;
            2'b01: srcb = INSTR_BYTES;
            2'b10: srcb = signimm;
            2'b11: srcb = signimm << SH;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alucontrol)
            3'b000:  alu_result = srca & srcb;
            3'b001:  alu_result = srca | srcb;
            3'b010:  alu_result = srca + srcb;
            3'b110:  alu_result = srca - srcb;
            3'b111:  alu_result = {{(N-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    always_comb begin
        pcnext = pc_q;
        unique case (pcsrc)
            2'b00: pcnext = alu_result;
            2'b01: pcnext = aluout_q;
            // Jump keeps the PC's top bits above the word-aligned jump field
            2'b10: pcnext = {pc_q[N-1:N-3+SH], ir_q[N-4:0], {SH{1'b0}}};
            2'b11: pcnext = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            data_q   <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            // A, B and ALUOut recompute every cycle, even during a stall
            a_q      <= rf_q[rs];
            b_q      <= rf_q[rt];
            aluout_q <= alu_result;
            if (mem_ready) begin
                data_q <= readdata;
                if (irwrite) ir_q <= readdata;
                if (pcen) pc_q <= pcnext;
                // Register 0 is hardwired to zero by never being written
                if (regwrite && (writereg != '0)) rf_q[writereg] <= wbdata;
            end
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
module tb_mc_datapath;

    logic        clk, reset, mem_ready, pcen, iord, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic [15:0] rd16, adr16, wd16;
    logic [31:0] rd32, adr32, wd32;
    logic [2:0]  op16, op32;
    logic        zero16, zero32;

    mc_datapath #(.N(16), .RA_W(3), .IMM_W(7), .RESET_PC(16'h0040)) dut16 (
        .clk(clk), .reset(reset), .mem_ready(mem_ready), .pcen(pcen), .iord(iord),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol), .pcsrc(pcsrc),
        .readdata(rd16), .adr(adr16), .writedata(wd16), .op(op16), .zero(zero16)
    );

    mc_datapath #(.N(32), .RA_W(3), .IMM_W(7), .RESET_PC(32'h0000_0100)) dut32 (
        .clk(clk), .reset(reset), .mem_ready(mem_ready), .pcen(pcen), .iord(iord),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol), .pcsrc(pcsrc),
        .readdata(rd32), .adr(adr32), .writedata(wd32), .op(op32), .zero(zero32)
    );

    always #5 clk = ~clk;

    localparam int A16 = 0, WD16 = 1, OP16 = 2, Z16 = 3, A32 = 4, WD32 = 5, OP32 = 6;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            A16:     return {16'h0, adr16};
            WD16:    return {16'h0, wd16};
            OP16:    return {29'h0, op16};
            Z16:     return {31'h0, zero16};
            A32:     return adr32;
            WD32:    return wd32;
            OP32:    return {29'h0, op32};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic idle();
        mem_ready = 1'b1; pcen = 1'b0; iord = 1'b0; irwrite = 1'b0; regdst = 1'b0;
        memtoreg = 1'b0; regwrite = 1'b0; alusrca = 1'b0; alusrcb = 2'b00;
        alucontrol = 3'b000; pcsrc = 2'b11;
    endtask

    task automatic fetch_ctl();
        idle(); irwrite = 1'b1; pcen = 1'b1; alusrcb = 2'b01; alucontrol = 3'b010; pcsrc = 2'b00;
    endtask

    task automatic load_ir(input logic [15:0] i16, input logic [31:0] i32);
        idle(); irwrite = 1'b1; rd16 = i16; rd32 = i32;
        tick();
        idle();
    endtask

    // Data <= v, then write it into RF[rt] of the current IR
    task automatic write_rf(input logic [15:0] v16, input logic [31:0] v32);
        idle(); rd16 = v16; rd32 = v32;
        tick();
        regwrite = 1'b1; memtoreg = 1'b1; rd16 = '0; rd32 = '0;
        tick();
        idle();
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1;
        push("rst_adr16", A16, 32'h0040);
        push("rst_wd16", WD16, 32'h0);
        push("rst_op16", OP16, 32'h0);
        push("rst_adr32", A32, 32'h0100);
        push("rst_wd32", WD32, 32'h0);
        drain();
        #1 reset = 1'b1;
    endtask

    function automatic logic [15:0] enc16(input logic [2:0] o, input logic [2:0] s,
                                          input logic [2:0] t, input logic [2:0] d);
        return {o, s, t, d, 4'b0000};
    endfunction

    function automatic logic [31:0] enc32(input logic [2:0] o, input logic [2:0] s,
                                          input logic [2:0] t, input logic [2:0] d);
        return {o, s, t, d, 20'h0};
    endfunction

    logic [2:0]  alu_ops [7] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100};
    logic [15:0] alu_exp [7] = '{16'd1, 16'd7, 16'd8, 16'd2, 16'd0, 16'd0, 16'd0};

    initial begin
        clk = 1'b0; reset = 1'b1; rd16 = '0; rd32 = '0;
        idle();
        pulse_reset();

        // Fetch, then a three-cycle stall
        fetch_ctl(); rd16 = 16'h2A85;
        push("fetch_adr", A16, 32'h42); push("fetch_op", OP16, 32'd1);
        tick();
        rd16 = 16'h4000; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push("stall_adr", A16, 32'h42); push("stall_op", OP16, 32'd1);
            tick();
        end
        mem_ready = 1'b1;
        push("resume_adr", A16, 32'h44); push("resume_op", OP16, 32'd2);
        tick();

        // RF[2] = 5, checking the write edge reads the old value
        load_ir(enc16(0, 0, 2, 0), 32'h0);
        rd16 = 16'd5;
        tick();
        regwrite = 1'b1; memtoreg = 1'b1; rd16 = '0;
        push("no_bypass", WD16, 32'h0);
        tick();
        idle();
        push("rf2", WD16, 32'd5);
        tick();

        // RF[3] = 3, then SUB r4 = r2 - r3
        load_ir(enc16(0, 0, 3, 0), 32'h0);
        write_rf(16'd3, 32'h0);
        load_ir(enc16(0, 2, 3, 4), 32'h0);
        alusrca = 1'b1; alucontrol = 3'b110;
        tick();
        push("sub_zero", Z16, 32'd0); drain();
        iord = 1'b1;
        push("sub_aluout", A16, 32'd2);
        tick();
        regwrite = 1'b1; regdst = 1'b1; memtoreg = 1'b0;
        tick();
        load_ir(enc16(0, 0, 4, 0), 32'h0);
        push("rf4_sub", WD16, 32'd2);
        tick();

        // Equal operands
        load_ir(enc16(0, 3, 3, 0), 32'h0);
        alusrca = 1'b1; alucontrol = 3'b110;
        tick();
        push("sub_eq_zero", Z16, 32'd1); drain();

        // ALU operations with A=5, B=3
        load_ir(enc16(0, 2, 3, 0), 32'h0);
        tick();
        for (int i = 0; i < 7; i++) begin
            idle(); alusrca = 1'b1; iord = 1'b1; alucontrol = alu_ops[i];
            push($sformatf("alu_%b", alu_ops[i]), A16, {16'h0, alu_exp[i]});
            tick();
        end
        load_ir(enc16(0, 3, 2, 0), 32'h0);
        tick();
        alusrca = 1'b1; iord = 1'b1; alucontrol = 3'b111;
        push("slt_lt", A16, 32'd1);
        tick();

        // Writes to r0 are discarded
        load_ir(enc16(0, 0, 0, 0), 32'h0);
        write_rf(16'h1234, 32'h0);
        push("r0_zero", WD16, 32'h0);
        tick();

        // Branch target and jump
        idle();
        pulse_reset();
        fetch_ctl(); rd16 = 16'h007E;
        push("fetch2_adr", A16, 32'h42);
        tick();
        idle(); alusrcb = 2'b11; alucontrol = 3'b010; iord = 1'b1;
        push("branch_aluout", A16, 32'h3E);
        tick();
        idle(); pcen = 1'b1; pcsrc = 2'b01;
        push("pc_aluout", A16, 32'h3E);
        tick();
        load_ir(16'h0100, 32'h0);
        pcen = 1'b1; pcsrc = 2'b10;
        push("jump", A16, 32'h0200);
        tick();
        idle(); pcen = 1'b1; pcsrc = 2'b11;
        push("pc_hold", A16, 32'h0200);
        tick();

        // PC, IR and RF written on the same edge; RF uses the old IR
        load_ir(enc16(0, 0, 5, 0), 32'h0);
        fetch_ctl(); rd16 = enc16(0, 0, 6, 0); regwrite = 1'b1; memtoreg = 1'b1;
        push("simul_pc", A16, 32'h0202);
        tick();
        load_ir(enc16(0, 0, 5, 0), 32'h0);
        push("simul_rf5", WD16, 32'h0280);
        tick();

        // Reset mid-instruction, then a fresh fetch
        fetch_ctl(); rd16 = 16'hE000;
        pulse_reset();
        push("refetch_adr", A16, 32'h42); push("refetch_op", OP16, 32'd7);
        tick();

        // 32-bit datapath
        idle();
        pulse_reset();
        fetch_ctl(); rd16 = '0; rd32 = enc32(3'b101, 0, 0, 0);
        push("fetch32_adr", A32, 32'h104); push("fetch32_op", OP32, 32'd5);
        tick();
        push("fetch32_adr2", A32, 32'h108);
        tick();
        load_ir(16'h0, enc32(0, 0, 1, 0));
        write_rf(16'h0, 32'h8000_0000);
        load_ir(16'h0, enc32(0, 0, 2, 0));
        write_rf(16'h0, 32'h1);
        load_ir(16'h0, enc32(0, 1, 2, 0));
        tick();
        alusrca = 1'b1; iord = 1'b1; alucontrol = 3'b111;
        push("slt32_neg", A32, 32'h1);
        tick();
        alucontrol = 3'b010;
        push("add32", A32, 32'h8000_0001);
        tick();
        load_ir(16'h0, enc32(0, 2, 1, 0));
        tick();
        alusrca = 1'b1; iord = 1'b1; alucontrol = 3'b111;
        push("slt32_pos", A32, 32'h0);
        tick();
        load_ir(16'h0, 32'h0000_007F);
        alusrcb = 2'b11; alucontrol = 3'b010; iord = 1'b1;
        push("branch32", A32, 32'h104);
        tick();
        idle(); pcen = 1'b1; pcsrc = 2'b10;
        push("jump32", A32, 32'h1FC);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
